pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, 4, number of stall cycles a multiply holds EX; legal range 2..16.
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 id_rs1_idx, id_rs2_idx  in  5 each  source register indices of the instruction in ID.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_ld_ins  in  1  instruction in EX is a load (ID/EX control bit 5).
REQ-007 ex_rd_idx  in  5  destination index of the instruction in EX.
REQ-008 ex_mul_ins  in  1  instruction in EX is a multiply (ID/EX control bit 6).
REQ-009 ex_br_taken  in  1  branch in EX resolved taken this cycle.
REQ-010 dmem_miss  in  1  MEM-stage data access missed; held high by memory until serviced.
REQ-011 dmem_ready  in  1  data miss serviced, single-cycle pulse.
REQ-012 imem_miss  in  1  instruction fetch missed this cycle.
REQ-013 pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  write enables for PC and the IF/ID, ID/EX, EX/MEM registers.
REQ-014 id_ex_bubble  out  1  forces zero into all ID/EX control bits on the next write.
REQ-015 if_id_flush  out  1  forces a NOP into IF/ID on the next write.
REQ-016 state_out  out  2  current state: RUN=0, MUL_WAIT=1, MEM_WAIT=2.

Function
REQ-017 Block SHALL hold FSM {RUN, MUL_WAIT, MEM_WAIT}, a 4-bit down-counter cnt and a mul_done flag; all outputs combinational from state and inputs.
REQ-018 RUN default: all four we=1, id_ex_bubble=0, if_id_flush=0.
REQ-019 Priority in RUN, highest first: dmem_miss, multiply start, ex_br_taken, load-use, imem_miss.
REQ-020 dmem_miss=1 in RUN: all four we=0, go MEM_WAIT; lower-priority events ignored that cycle.
REQ-021 MEM_WAIT: all we=0 while dmem_ready=0; dmem_ready=1: all we=1, go RUN same edge.
REQ-022 Multiply start = RUN, ex_mul_ins=1, mul_done=0: all we=0, cnt<=MUL_LAT-2, go MUL_WAIT.
REQ-023 MUL_WAIT: all we=0; cnt!=0: decrement; cnt==0: set mul_done, go MEM_WAIT if dmem_miss=1 else RUN.
REQ-024 Net multiply cost: exactly MUL_LAT stall cycles; multiply advances to EX/MEM in cycle MUL_LAT+1.
REQ-025 mul_done SHALL clear on any edge where id_ex_we=1 in RUN; while set, ex_mul_ins ignored.
REQ-026 ex_br_taken=1 (no higher event): pc_we=1, if_id_flush=1, id_ex_bubble=1, other we=1.
REQ-027 Load-use = ex_ld_ins=1, ex_rd_idx!=0, and (id_rs1_used and id_rs1_idx==ex_rd_idx) or (id_rs2_used and id_rs2_idx==ex_rd_idx).
REQ-028 Load-use (no higher event): pc_we=0, if_id_we=0, id_ex_we=1, id_ex_bubble=1, ex_mem_we=1; one cycle only.
REQ-029 imem_miss=1 (no higher event): pc_we=0, if_id_flush=1, all other we=1, bubble=0.
REQ-030 Index 0 SHALL never cause a load-use stall.

Reset
REQ-031 While reset=0: state RUN, cnt=0, mul_done=0, all we=0, id_ex_bubble=1, if_id_flush=1, state_out=0.
REQ-032 Reset asserted in MUL_WAIT or MEM_WAIT SHALL abort the wait; first cycle after release behaves as RUN.

Verification
REQ-033 Load r5 in EX, ID reads rs2=5 used -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle all we=1.
REQ-034 MUL_LAT=4, ex_mul_ins held 1 -> 4 cycles all we=0 (state 0,1,1,1), cycle 5 all we=1, no re-trigger.
REQ-035 dmem_miss high 3 cycles then dmem_ready pulse -> we=0 for 3 cycles, we=1 in ready cycle, state 0->2->0.
REQ-036 ex_br_taken with simultaneous load-use and imem_miss -> pc_we=1, if_id_flush=1, id_ex_bubble=1.
REQ-037 Load with ex_rd_idx=0, ID rs1=0 used -> no stall, all we=1.
REQ-038 reset low during MUL_WAIT cnt=2 -> immediately state_out=0, we=0, bubble=1; after release RUN defaults.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: multiply/data-miss stall FSM plus branch, load-use and fetch-miss handling.
// Outputs are combinational from state and inputs (zero latency); stalls are signalled by dropping register write enables.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1_idx,
  input  logic [4:0] id_rs2_idx,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_ld_ins,
  input  logic [4:0] ex_rd_idx,
  input  logic       ex_mul_ins,
  input  logic       ex_br_taken,
  input  logic       dmem_miss,
  input  logic       dmem_ready,
  input  logic       imem_miss,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       ex_mem_we,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // The cycle that detects the multiply and the final zero-count cycle are both stalls,
  // so the counter starts two short of the full latency.
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       mul_done;
  logic       mul_done_nxt;
  logic       load_use;
  logic       mul_start;

  assign load_use = ex_ld_ins && (ex_rd_idx != 5'd0) &&
                    ((id_rs1_used && (id_rs1_idx == ex_rd_idx)) ||
                     (id_rs2_used && (id_rs2_idx == ex_rd_idx)));

  // mul_done keeps a finished multiply still sitting in EX from starting a second stall.
  assign mul_start = ex_mul_ins && !mul_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      cnt      <= 4'd0;
      mul_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mul_done <= mul_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mul_done_nxt = mul_done;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;

    case (state)
      RUN: begin
        if (dmem_miss) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
          state_nxt = MEM_WAIT;
        end else if (mul_start) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
          cnt_nxt   = CNT_INIT;
          state_nxt = MUL_WAIT;
        end else if (ex_br_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (imem_miss) begin
          pc_we       = 1'b0;
          if_id_flush = 1'b1;
        end
        if (id_ex_we) begin
          mul_done_nxt = 1'b0;
        end
      end

      MUL_WAIT: begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          mul_done_nxt = 1'b1;
          state_nxt    = dmem_miss ? MEM_WAIT : RUN;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end else begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
        end
      end

      default: begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        state_nxt = RUN;
      end
    endcase

    // While reset is held the pipeline is frozen and fed NOPs.
    if (!reset) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios with hand-derived vectors, then random traffic
// checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic       id_rs1_used, id_rs2_used, ex_ld_ins, ex_mul_ins, ex_br_taken;
  logic       dmem_miss, dmem_ready, imem_miss;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, id_ex_bubble, if_id_flush;
  logic [1:0] state_out;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_ld_ins(ex_ld_ins), .ex_rd_idx(ex_rd_idx),
    .ex_mul_ins(ex_mul_ins), .ex_br_taken(ex_br_taken),
    .dmem_miss(dmem_miss), .dmem_ready(dmem_ready), .imem_miss(imem_miss),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, mul, br, dmiss, drdy, imiss;
  } stim_t;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  // Output vector layout: {state[1:0], pc_we, if_id_we, id_ex_we, ex_mem_we, bubble, flush}
  localparam logic [7:0] V_RESET = 8'b00_0000_11;
  localparam logic [7:0] V_RUN   = 8'b00_1111_00;
  localparam logic [7:0] V_STALL = 8'b00_0000_00;
  localparam logic [7:0] V_MULW  = 8'b01_0000_00;
  localparam logic [7:0] V_MEMW  = 8'b10_0000_00;
  localparam logic [7:0] V_MEMR  = 8'b10_1111_00;
  localparam logic [7:0] V_LDUSE = 8'b00_0011_10;
  localparam logic [7:0] V_BR    = 8'b00_1111_11;

  sb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;

  // Model state: which wait we are in, how many multiply stall cycles remain, and whether
  // the multiply now in EX has already been paid for.
  int m_mode = 0;  // 0 running, 1 multiply wait, 2 memory wait
  int m_left = 0;
  bit m_paid = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.rs1 = 5'd0; s.rs2 = 5'd0; s.rd = 5'd0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.ld = 1'b0; s.mul = 1'b0; s.br = 1'b0;
    s.dmiss = 1'b0; s.drdy = 1'b0; s.imiss = 1'b0;
    return s;
  endfunction

  function automatic logic [7:0] model_out(stim_t s);
    bit hazard;
    hazard = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (!s.rst_n)            return V_RESET;
    if (m_mode == 1)         return V_MULW;
    if (m_mode == 2)         return s.drdy ? V_MEMR : V_MEMW;
    if (s.dmiss)             return V_STALL;
    if (s.mul && !m_paid)    return V_STALL;
    if (s.br)                return V_BR;
    if (hazard)              return V_LDUSE;
    if (s.imiss)             return 8'b00_0111_01;
    return V_RUN;
  endfunction

  task automatic model_advance(stim_t s, logic [7:0] o);
    if (!s.rst_n) begin
      m_mode = 0; m_left = 0; m_paid = 0;
    end else if (m_mode == 0) begin
      if (s.dmiss) m_mode = 2;
      else if (s.mul && !m_paid) begin
        m_mode = 1;
        m_left = MUL_LAT - 1;
      end else if (o[3]) m_paid = 0;
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_paid = 1;
        m_mode = s.dmiss ? 2 : 0;
      end
    end else if (s.drdy) begin
      m_mode = 0;
    end
  endtask

  task automatic drive(stim_t s);
    reset = s.rst_n; id_rs1_idx = s.rs1; id_rs2_idx = s.rs2; ex_rd_idx = s.rd;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_ld_ins = s.ld; ex_mul_ins = s.mul;
    ex_br_taken = s.br; dmem_miss = s.dmiss; dmem_ready = s.drdy; imem_miss = s.imiss;
  endtask

  // One cycle: drive just after the edge, push the expectation, advance the model.
  task automatic step(stim_t s, bit use_const, logic [7:0] c_exp, string name);
    sb_t e;
    logic [7:0] m;
    @(posedge clk);
    #1;
    drive(s);
    m = model_out(s);
    e.exp  = use_const ? c_exp : m;
    e.name = name;
    sb_q.push_back(e);
    model_advance(s, m);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        sb_t e;
        logic [7:0] act;
        e = sb_q.pop_front();
        act = {state_out, pc_we, if_id_we, id_ex_we, ex_mem_we, id_ex_bubble, if_id_flush};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (state,pc,ifid,idex,exmem,bubble,flush)",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    stim_t s;
    drive(idle());
    reset = 1'b0;

    s = idle(); s.rst_n = 1'b0;
    step(s, 1, V_RESET, "reset_hold0");
    step(s, 1, V_RESET, "reset_hold1");
    step(idle(), 1, V_RUN, "run_default");

    s = idle(); s.ld = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1;
    step(s, 1, V_LDUSE, "load_use_rs2");
    step(idle(), 1, V_RUN, "load_use_release");

    s = idle(); s.mul = 1;
    step(s, 1, V_STALL, "mul_c1");
    step(s, 1, V_MULW,  "mul_c2");
    step(s, 1, V_MULW,  "mul_c3");
    step(s, 1, V_MULW,  "mul_c4");
    step(s, 1, V_RUN,   "mul_c5_no_retrigger");
    step(idle(), 1, V_RUN, "mul_after");

    s = idle(); s.dmiss = 1;
    step(s, 1, V_STALL, "dmiss_c1");
    step(s, 1, V_MEMW,  "dmiss_c2");
    step(s, 1, V_MEMW,  "dmiss_c3");
    s.drdy = 1;
    step(s, 1, V_MEMR,  "dmiss_ready");
    step(idle(), 1, V_RUN, "dmiss_back_run");

    s = idle(); s.br = 1; s.ld = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1; s.imiss = 1;
    step(s, 1, V_BR, "branch_priority");

    s = idle(); s.imiss = 1;
    step(s, 1, 8'b00_0111_01, "imem_miss");

    s = idle(); s.ld = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1;
    step(s, 1, V_RUN, "load_r0_no_stall");

    s = idle(); s.ld = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 0; s.rs2 = 5'd7; s.u2 = 0;
    step(s, 1, V_RUN, "load_unused_src");

    s = idle(); s.mul = 1;
    step(s, 1, V_STALL, "mul_abort_start");
    step(s, 1, V_MULW,  "mul_abort_wait");
    s.rst_n = 0;
    step(s, 1, V_RESET, "mul_abort_reset");
    step(idle(), 1, V_RUN, "mul_abort_release");

    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 63) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.mul   = ($urandom_range(0, 4) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.dmiss = ($urandom_range(0, 7) == 0);
      s.drdy  = ($urandom_range(0, 3) == 0);
      s.imiss = ($urandom_range(0, 4) == 0);
      step(s, 0, 8'd0, "random");
    end

    step(idle(), 0, 8'd0, "drain");
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
